aes_block_loader: RTL and testbench

Stream front-end for the 128-bit fully pipelined AES-128 encryption core. It assembles a 128-bit key and 128-bit plaintext blocks from 32-bit word streams, then presents each block together with its key to the core. It tracks each issued block through the core's fixed latency with a valid-tag shift register. It flags the ciphertext at the core output as valid, and keeps in-flight and completed-block counts.

---
 rtl/aes_block_loader.sv | 111 +++++++++++
 tb/tb_aes_block_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Stream front-end for a fully pipelined AES-128 core: packs 32-bit key and
// plaintext words into 128-bit blocks and tags each block through the core latency.
module aes_block_loader #(
   parameter int LATENCY = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_wr,
   input  logic [31:0]  key_word,
   output logic         key_valid,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   output logic [127:0] core_data,
   output logic [127:0] core_key,
   output logic         core_issue,
   input  logic [127:0] core_ct,
   output logic         m_valid,
   output logic [127:0] m_ct,
   output logic [4:0]   in_flight,
   output logic [15:0]  blk_cnt,
   output logic         idle
);

   logic [1:0]         kc_r;
   logic [95:0]        key_stage_r;
   logic [1:0]         wc_r;
   logic [95:0]        data_buf_r;
   logic [LATENCY-1:0] tag_r;
   logic               accept_s;
   logic [4:0]         in_flight_next_s;

   assign accept_s = s_valid & key_valid;
   assign s_ready  = key_valid;
   assign m_valid  = tag_r[LATENCY-1];
   assign m_ct     = core_ct;
   assign idle     = (in_flight == 5'd0) && (wc_r == 2'd0);

   // Key word collection; the active key switches only on the fourth word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kc_r        <= 2'd0;
         key_stage_r <= 96'd0;
         core_key    <= 128'd0;
         key_valid   <= 1'b0;
      end else if (key_wr) begin
         if (kc_r == 2'd3) begin
            core_key  <= {key_stage_r, key_word};
            key_valid <= 1'b1;
            kc_r      <= 2'd0;
         end else begin
            key_stage_r <= {key_stage_r[63:0], key_word};
            kc_r        <= kc_r + 2'd1;
         end
      end else begin
         kc_r <= kc_r;
      end
   end

   // Plaintext block assembly and single-cycle issue pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wc_r       <= 2'd0;
         data_buf_r <= 96'd0;
         core_data  <= 128'd0;
         core_issue <= 1'b0;
      end else begin
         core_issue <= 1'b0;
         if (accept_s) begin
            if (wc_r == 2'd3) begin
               core_data  <= {data_buf_r, s_data};
               core_issue <= 1'b1;
               wc_r       <= 2'd0;
            end else begin
               data_buf_r <= {data_buf_r[63:0], s_data};
               wc_r       <= wc_r + 2'd1;
            end
         end else begin
            wc_r <= wc_r;
         end
      end
   end

   // Next in-flight count: an issue and a return in one cycle cancel out.
   always_comb begin
      in_flight_next_s = in_flight;
      case ({core_issue, m_valid})
         2'b10:   in_flight_next_s = in_flight + 5'd1;
         2'b01:   in_flight_next_s = in_flight - 5'd1;
         default: in_flight_next_s = in_flight;
      endcase
   end

   // Valid-tag pipeline mirroring the core latency, plus block accounting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_r     <= '0;
         in_flight <= 5'd0;
         blk_cnt   <= 16'd0;
      end else begin
         tag_r     <= (tag_r << 1) | LATENCY'(core_issue);
         in_flight <= in_flight_next_s;
         if (m_valid) begin
            blk_cnt <= blk_cnt + 16'd1;
         end else begin
            blk_cnt <= blk_cnt;
         end
      end
   end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a behavioural pipelined AES-128 core
// and a scoreboard of expected ciphertexts and arrival cycles.
module tb_aes_block_loader;

   localparam int LATENCY = 12;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         key_wr = 1'b0;
   logic [31:0]  key_word = 32'd0;
   logic         key_valid;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = 32'd0;
   logic [127:0] core_data;
   logic [127:0] core_key;
   logic         core_issue;
   logic [127:0] core_ct;
   logic         m_valid;
   logic [127:0] m_ct;
   logic [4:0]   in_flight;
   logic [15:0]  blk_cnt;
   logic         idle;

   aes_block_loader #(.LATENCY(LATENCY)) dut (
      .clk(clk), .reset(reset), .key_wr(key_wr), .key_word(key_word),
      .key_valid(key_valid), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .core_data(core_data), .core_key(core_key), .core_issue(core_issue),
      .core_ct(core_ct), .m_valid(m_valid), .m_ct(m_ct), .in_flight(in_flight),
      .blk_cnt(blk_cnt), .idle(idle)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int peak     = 0;
   logic [127:0] last_ct = 128'd0;
   logic [127:0] key_model = 128'd0;
   logic [15:0]  blocks_sent = 16'd0;

   typedef struct {
      logic [127:0] ct;
      int           due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES-128 reference ----------------
   logic [2047:0] sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb8(input logic [7:0] x);
      return sbox_tab[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb8(tmp[23:16]), sb8(tmp[15:8]), sb8(tmp[7:0]), sb8(tmp[31:24])} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb8(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r != 10) begin
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Behavioural fully pipelined core fed by the loader outputs.
   logic [127:0] pipe [LATENCY];
   always @(posedge clk) begin
      pipe[0] <= aes_enc(core_key, core_data);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign core_ct = pipe[LATENCY-1];

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every m_valid.
   initial forever begin
      @(negedge clk);
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (m_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_m_valid", 128'(m_valid), 128'(1'b0));
         end else begin
            mon_e = sb.pop_front();
            check("m_ct", m_ct, mon_e.ct);
            check("m_valid_cycle", 128'(cyc), 128'(mon_e.due));
            last_ct = m_ct;
         end
      end
   end

   task automatic send(input logic [127:0] blk, input logic do_blk,
                       input logic [127:0] key, input logic do_key);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            check("issue_low", 128'(core_issue), 128'(1'b0));
            if (do_key) check("key_hold", core_key, key_model);
         end
         key_wr   = do_key;
         key_word = key[127-32*i -: 32];
         s_valid  = do_blk;
         s_data   = blk[127-32*i -: 32];
         if (i == 3) begin
            if (do_key) key_model = key;
            if (do_blk) begin
               sb.push_back('{ct: aes_enc(key_model, blk), due: cyc + 1 + LATENCY});
               blocks_sent++;
            end
         end
         tick();
      end
      key_wr  = 1'b0;
      s_valid = 1'b0;
      if (do_blk) begin
         check("issue_pulse", 128'(core_issue), 128'(1'b1));
         check("core_data", core_data, blk);
      end
      if (do_key) begin
         check("core_key", core_key, key);
         check("key_valid", 128'(key_valid), 128'(1'b1));
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 64; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check("drain", 128'(sb.size()), 128'(0));
   endtask

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;

   initial begin
      int mv_seen;
      // Reset, then plaintext without a key must be refused.
      repeat (3) tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = 32'hdead0000 + 32'(i);
         tick();
         check("nokey_s_ready", 128'(s_ready), 128'(1'b0));
         check("nokey_issue", 128'(core_issue), 128'(1'b0));
         check("nokey_idle", 128'(idle), 128'(1'b1));
      end
      s_valid = 1'b0;
      check("rst_key_valid", 128'(key_valid), 128'(1'b0));
      check("rst_core_data", core_data, 128'd0);
      check("rst_core_key", core_key, 128'd0);
      check("rst_in_flight", 128'(in_flight), 128'(0));
      check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
      check("rst_m_valid", 128'(m_valid), 128'(1'b0));

      // FIPS-197 vector.
      send(128'd0, 1'b0, KEY_A, 1'b1);
      check("s_ready_after_key", 128'(s_ready), 128'(1'b1));
      send(PT_A, 1'b1, 128'd0, 1'b0);
      wait_drain();
      check("fips_ct", last_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check("blk_cnt_1", 128'(blk_cnt), 128'(blocks_sent));

      // Eight blocks at full rate.
      peak = 0;
      for (int b = 0; b < 8; b++) begin
         send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 128'd0, 1'b0);
      end
      wait_drain();
      check("peak_in_flight", 128'(peak), 128'(3));
      check("in_flight_zero", 128'(in_flight), 128'(0));
      check("idle_after_burst", 128'(idle), 128'(1'b1));
      check("blk_cnt_9", 128'(blk_cnt), 128'(blocks_sent));

      // Prior block under old key; reload coinciding with the next block.
      send(128'h0123456789abcdeffedcba9876543210, 1'b1, 128'd0, 1'b0);
      send(PT_A, 1'b1, KEY_B, 1'b1);
      wait_drain();
      check("blk_cnt_reload", 128'(blk_cnt), 128'(blocks_sent));

      // Reset with two blocks in flight.
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 128'd0, 1'b0);
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 128'd0, 1'b0);
      tick();
      check("in_flight_two", 128'(in_flight), 128'(2));
      reset = 1'b1;
      #1;
      check("mid_rst_in_flight", 128'(in_flight), 128'(0));
      check("mid_rst_key_valid", 128'(key_valid), 128'(1'b0));
      check("mid_rst_blk_cnt", 128'(blk_cnt), 128'(0));
      sb.delete();
      blocks_sent = 16'd0;
      key_model   = 128'd0;
      tick();
      tick();
      reset = 1'b0;
      mv_seen = 0;
      for (int i = 0; i < LATENCY + 4; i++) begin
         tick();
         if (m_valid === 1'b1) mv_seen++;
      end
      check("no_m_valid_after_rst", 128'(mv_seen), 128'(0));
      check("s_ready_after_rst", 128'(s_ready), 128'(1'b0));

      // Counter wrap from 65535.
      send(128'd0, 1'b0, KEY_B, 1'b1);
      force dut.blk_cnt = 16'hffff;
      #1;
      release dut.blk_cnt;
      blocks_sent = 16'hffff;
      send(PT_A, 1'b1, 128'd0, 1'b0);
      wait_drain();
      check("blk_cnt_wrap", 128'(blk_cnt), 128'(blocks_sent));
      check("idle_end", 128'(idle), 128'(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
